// File: rtl/dmem_arbiter.sv
// Arbiter sharing the data-memory port between the processor and a word-wide debug port.
// Optional stall statistics counter enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_access,
  input  logic [0:31] cpu_addr,
  input  logic [0:31] cpu_data_in,
  input  logic        cpu_write_enable,
  input  logic        cpu_byte,
  input  logic        cpu_half_word,
  input  logic        cpu_sign_extend,
  output logic [0:31] cpu_data_out,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_write,
  input  logic [0:31] dbg_addr,
  input  logic [0:31] dbg_wdata,
  output logic        dbg_ack,
  output logic [0:31] dbg_rdata,
  output logic [0:31] mem_addr,
  output logic [0:31] mem_data_in,
  output logic        mem_write_enable,
  output logic        mem_byte,
  output logic        mem_half_word,
  output logic        mem_sign_extend,
  input  logic [0:31] mem_data_out
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [0:31] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_dbg_ack;
  logic [0:31] r_dbg_rdata;

  logic        w_starve;
  logic        w_grant_dbg;

  // With MAX_WAIT==0 a request colliding with the processor is forced through from IDLE.
  assign w_starve = ((r_state == ST_WAIT) && (r_wait_cnt == LP_MAX_WAIT)) ||
                    ((r_state == ST_IDLE) && (LP_MAX_WAIT == 8'd0));

  assign w_grant_dbg = reset && dbg_req && (r_state != ST_ACK) &&
                       (!cpu_access || w_starve);

  always_comb begin
    if (w_grant_dbg) begin
      mem_addr         = dbg_addr;
      mem_data_in      = dbg_wdata;
      mem_write_enable = dbg_write;
      mem_byte         = 1'b0;
      mem_half_word    = 1'b0;
      mem_sign_extend  = 1'b0;
    end else begin
      mem_addr         = cpu_addr;
      mem_data_in      = cpu_data_in;
      mem_write_enable = reset && cpu_write_enable;
      mem_byte         = cpu_byte;
      mem_half_word    = cpu_half_word;
      mem_sign_extend  = cpu_sign_extend;
    end
  end

  assign cpu_data_out = mem_data_out;
  assign cpu_stall    = cpu_access && w_grant_dbg;
  assign dbg_ack      = r_dbg_ack;
  assign dbg_rdata    = r_dbg_rdata;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= '0;
    end else begin
      r_dbg_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_dbg) begin
            r_state     <= ST_ACK;
            r_dbg_ack   <= 1'b1;
            r_dbg_rdata <= mem_data_out;
          end else if (dbg_req) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (w_grant_dbg) begin
            r_state     <= ST_ACK;
            r_dbg_ack   <= 1'b1;
            r_dbg_rdata <= mem_data_out;
            r_wait_cnt  <= '0;
          end else if (!dbg_req) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [0:31] r_stall_cycles;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (cpu_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant timing and memory contents.
module tb_dmem_arbiter;

  localparam int unsigned MAXW = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_access;
  logic [0:31] cpu_addr;
  logic [0:31] cpu_data_in;
  logic        cpu_write_enable;
  logic        cpu_byte;
  logic        cpu_half_word;
  logic        cpu_sign_extend;
  logic [0:31] cpu_data_out;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_write;
  logic [0:31] dbg_addr;
  logic [0:31] dbg_wdata;
  logic        dbg_ack;
  logic [0:31] dbg_rdata;
  logic [0:31] mem_addr;
  logic [0:31] mem_data_in;
  logic        mem_write_enable;
  logic        mem_byte;
  logic        mem_half_word;
  logic        mem_sign_extend;
  logic [0:31] mem_data_out;
`ifdef DMEM_ARB_STATS_EN
  logic [0:31] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset),
    .cpu_access(cpu_access), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_write_enable(cpu_write_enable), .cpu_byte(cpu_byte),
    .cpu_half_word(cpu_half_word), .cpu_sign_extend(cpu_sign_extend),
    .cpu_data_out(cpu_data_out), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_byte(mem_byte),
    .mem_half_word(mem_half_word), .mem_sign_extend(mem_sign_extend),
    .mem_data_out(mem_data_out)
`ifdef DMEM_ARB_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Big-endian byte memory standing in for dmem: asynchronous read, write on rising edge.
  logic [7:0] mem [0:16383] = '{default: 8'h00};

  always_comb begin
    int unsigned a;
    a = mem_addr & 32'h3FFC;
    mem_data_out = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  end

  always @(posedge clock) begin
    int unsigned ab;
    ab = mem_addr & 32'h3FFF;
    if (mem_write_enable) begin
      if (mem_byte) begin
        mem[ab] <= mem_data_in[24:31];
      end else if (mem_half_word) begin
        mem[ab & 32'h3FFE]       <= mem_data_in[16:23];
        mem[(ab & 32'h3FFE) + 1] <= mem_data_in[24:31];
      end else begin
        mem[ab & 32'h3FFC]       <= mem_data_in[0:7];
        mem[(ab & 32'h3FFC) + 1] <= mem_data_in[8:15];
        mem[(ab & 32'h3FFC) + 2] <= mem_data_in[16:23];
        mem[(ab & 32'h3FFC) + 3] <= mem_data_in[24:31];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_set(input logic acc, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic bt);
    cpu_access       = acc;
    cpu_write_enable = we;
    cpu_addr         = addr;
    cpu_data_in      = data;
    cpu_byte         = bt;
    cpu_half_word    = 1'b0;
    cpu_sign_extend  = 1'b0;
  endtask

  task automatic dbg_set(input logic req, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
    dbg_req   = req;
    dbg_write = wr;
    dbg_addr  = addr;
    dbg_wdata = data;
  endtask

  // Transaction-level model state for the randomized phase
  logic [31:0] model_mem [0:4095];
  bit          pending, in_ack, last_write, exp_grant, exp_stall;
  int unsigned k;
  logic [31:0] exp_rdata;

  initial begin
    for (int i = 0; i < 4096; i++) model_mem[i] = 32'h0;

    // Reset held with everything requesting
    reset = 1'b0;
    cpu_set(1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 1'b0);
    dbg_set(1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D);
    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      #2;
      chk("rst_mem_we", mem_write_enable, 1'b0);
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_ack", dbg_ack, 1'b0);
      chk("rst_rdata", dbg_rdata, 32'h0);
      chk("rst_addr", mem_addr, 32'h0000_0100);
    end

    next_cycle();
    reset = 1'b1;
    cpu_set(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);

    // Idle debug store
    next_cycle();
    dbg_set(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF);
    #1;
    chk("st_c1_we", mem_write_enable, 1'b1);
    chk("st_c1_addr", mem_addr, 32'h0000_2000);
    chk("st_c1_data", mem_data_in, 32'hDEAD_BEEF);
    chk("st_c1_ack", dbg_ack, 1'b0);
    next_cycle();
    #1;
    chk("st_c2_ack", dbg_ack, 1'b1);
    chk("st_c2_we", mem_write_enable, 1'b0);
    next_cycle();
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("st_c3_ack", dbg_ack, 1'b0);
    chk("st_b0", mem[16'h2000], 8'hDE);
    chk("st_b1", mem[16'h2001], 8'hAD);
    chk("st_b2", mem[16'h2002], 8'hBE);
    chk("st_b3", mem[16'h2003], 8'hEF);

    // Preload 0x2004 through the debug port
    next_cycle();
    dbg_set(1'b1, 1'b1, 32'h0000_2004, 32'h0000_0037);
    next_cycle();
    next_cycle();
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);

    // Idle debug load, data held after ack
    next_cycle();
    dbg_set(1'b1, 1'b0, 32'h0000_2004, 32'h0);
    #1;
    chk("ld_c1_ack", dbg_ack, 1'b0);
    next_cycle();
    #1;
    chk("ld_c2_ack", dbg_ack, 1'b1);
    chk("ld_c2_rdata", dbg_rdata, 32'h0000_0037);
    next_cycle();
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("ld_c3_ack", dbg_ack, 1'b0);
    chk("ld_c3_hold", dbg_rdata, 32'h0000_0037);
    next_cycle();
    #1;
    chk("ld_c4_hold", dbg_rdata, 32'h0000_0037);

    // Starvation, three times, processor busy every cycle
    for (int rep = 0; rep < 3; rep++) begin
      for (int c = 1; c <= 7; c++) begin
        next_cycle();
        cpu_set(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
        if (c <= 6) dbg_set(1'b1, 1'b0, 32'h0000_2004, 32'h0);
        else        dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        if (c <= 4) begin
          chk($sformatf("starve_c%0d_stall", c), cpu_stall, 1'b0);
          chk($sformatf("starve_c%0d_addr", c), mem_addr, 32'h0000_0100);
        end else if (c == 5) begin
          chk("starve_c5_stall", cpu_stall, 1'b1);
          chk("starve_c5_addr", mem_addr, 32'h0000_2004);
          chk("starve_c5_ack", dbg_ack, 1'b0);
        end else if (c == 6) begin
          chk("starve_c6_ack", dbg_ack, 1'b1);
          chk("starve_c6_stall", cpu_stall, 1'b0);
          chk("starve_c6_rdata", dbg_rdata, 32'h0000_0037);
        end else begin
          chk("starve_c7_ack", dbg_ack, 1'b0);
          chk("starve_c7_stall", cpu_stall, 1'b0);
        end
      end
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stats_three", stall_cycles, 32'd3);
`endif

    // Collision: processor byte store wins while the debug load waits
    next_cycle();
    cpu_set(1'b1, 1'b1, 32'h0000_2008, 32'h0000_00AB, 1'b1);
    dbg_set(1'b1, 1'b0, 32'h0000_2000, 32'h0);
    #1;
    chk("col_c1_byte", mem_byte, 1'b1);
    chk("col_c1_addr", mem_addr, 32'h0000_2008);
    chk("col_c1_we", mem_write_enable, 1'b1);
    chk("col_c1_stall", cpu_stall, 1'b0);
    next_cycle();
    cpu_set(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    #1;
    chk("col_c2_addr", mem_addr, 32'h0000_2000);
    chk("col_c2_byte", mem_byte, 1'b0);
    chk("col_c2_we", mem_write_enable, 1'b0);
    chk("col_mem", mem[16'h2008], 8'hAB);
    next_cycle();
    #1;
    chk("col_c3_ack", dbg_ack, 1'b1);
    chk("col_c3_rdata", dbg_rdata, 32'hDEAD_BEEF);
    next_cycle();
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset while waiting drops the request without an ack
    next_cycle();
    cpu_set(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    dbg_set(1'b1, 1'b0, 32'h0000_2004, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rstw_stall", cpu_stall, 1'b0);
    chk("rstw_addr", mem_addr, 32'h0000_0100);
    next_cycle();
    reset = 1'b1;
    cpu_set(1'b0, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    dbg_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rstw_ack0", dbg_ack, 1'b0);
    chk("rstw_rdata", dbg_rdata, 32'h0);
`ifdef DMEM_ARB_STATS_EN
    chk("stats_reset", stall_cycles, 32'd0);
`endif
    next_cycle();
    #1;
    chk("rstw_ack1", dbg_ack, 1'b0);

    // Randomized traffic against the transaction model
    pending = 1'b0;
    in_ack = 1'b0;
    last_write = 1'b0;
    k = 0;
    exp_rdata = 32'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      next_cycle();
      cpu_set(($urandom_range(0, 99) < 85), 1'b0, 32'h100 + ($urandom_range(0, 63) << 2),
              $urandom, 1'b0);
      cpu_write_enable = cpu_access && ($urandom_range(0, 1) == 1);
      if (in_ack) begin
        dbg_req = 1'b1;
      end else if (!pending) begin
        if ($urandom_range(0, 2) == 0) begin
          dbg_set(1'b1, 1'($urandom_range(0, 1)), 32'h3000 + ($urandom_range(0, 15) << 2),
                  $urandom);
          pending = 1'b1;
          k = 0;
        end else begin
          dbg_req = 1'b0;
        end
      end
      #1;
      exp_grant = pending && !in_ack && (!cpu_access || k == MAXW);
      exp_stall = cpu_access && exp_grant;
      chk("rnd_ack", dbg_ack, in_ack);
      chk("rnd_stall", cpu_stall, exp_stall);
      chk("rnd_addr", mem_addr, exp_grant ? dbg_addr : cpu_addr);
      chk("rnd_we", mem_write_enable, exp_grant ? dbg_write : cpu_write_enable);
      chk("rnd_byte", mem_byte, 1'b0);
      if (in_ack && !last_write) chk("rnd_rdata", dbg_rdata, exp_rdata);

      if (in_ack) begin
        in_ack = 1'b0;
      end else if (exp_grant) begin
        if (dbg_write) model_mem[(dbg_addr & 32'h3FFC) >> 2] = dbg_wdata;
        else           exp_rdata = model_mem[(dbg_addr & 32'h3FFC) >> 2];
        last_write = dbg_write;
        pending = 1'b0;
        in_ack = 1'b1;
      end else if (pending) begin
        k++;
      end
      if (cpu_access && cpu_write_enable && !exp_stall)
        model_mem[(cpu_addr & 32'h3FFC) >> 2] = cpu_data_in;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
